// File: rtl/snoop_emissor_multi.sv
// MSI/MESI snooping-coherence emitter tracking state and tag for LINES direct-mapped lines.
// Turns each processor access into WRITEBACK / miss / INVALIDATE bus messages and updates the line on completion.
//
// state | meaning
// IDLE  | ready to accept a processor access
// WB    | WRITEBACK of the dirty resident line pending on the bus
// MISS  | READ_MISS, WRITE_MISS or INVALIDATE pending on the bus
// DONE  | completion pulse; line update already applied
module snoop_emissor_multi #(
    parameter int LINES     = 4,
    parameter int TAG_W     = 8,
    parameter int EXCLUSIVE = 0,
    localparam int IDX_W    = $clog2(LINES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [IDX_W-1:0]       req_index,
    input  logic [TAG_W-1:0]       req_tag,
    output logic                   req_ready,
    output logic                   bus_valid,
    output logic [2:0]             bus_msg,
    output logic [TAG_W+IDX_W-1:0] bus_addr,
    input  logic                   bus_grant,
    input  logic                   shared_in,
    output logic                   done,
    output logic [1:0]             result
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;
    localparam logic [1:0] ST_E = 2'b11;

    localparam logic [2:0] MSG_NONE  = 3'b000;
    localparam logic [2:0] MSG_WMISS = 3'b001;
    localparam logic [2:0] MSG_RMISS = 3'b010;
    localparam logic [2:0] MSG_INV   = 3'b011;
    localparam logic [2:0] MSG_WB    = 3'b100;

    typedef enum logic [1:0] {IDLE, WB, MISS, DONE} fsm_t;

    fsm_t fsm, fsm_nxt;

    logic [1:0]       line_state [LINES];
    logic [TAG_W-1:0] line_tag   [LINES];

    logic             lat_write;
    logic             lat_hit;
    logic [IDX_W-1:0] lat_index;
    logic [TAG_W-1:0] lat_tag;

    logic             write_nxt;
    logic             hit_nxt;
    logic [IDX_W-1:0] index_nxt;
    logic [TAG_W-1:0] tag_nxt;

    logic                   accept;
    logic                   grant;
    logic                   req_hit;
    logic [1:0]             cur_state;
    logic [TAG_W-1:0]       cur_tag;
    logic [1:0]             fill_state;
    logic [2:0]             msg_nxt;
    logic [TAG_W+IDX_W-1:0] addr_nxt;

    assign cur_state = line_state[req_index];
    assign cur_tag   = line_tag[req_index];
    assign req_hit   = (cur_state != ST_I) && (cur_tag == req_tag);
    assign accept    = req_valid && (fsm == IDLE);
    assign grant     = bus_valid && bus_grant;

    // shared_in only matters for a read fill, and only when E is enabled
    assign fill_state = lat_write ? ST_M :
                        ((EXCLUSIVE != 0) && !shared_in) ? ST_E : ST_S;

    always_comb begin
        fsm_nxt   = fsm;
        write_nxt = lat_write;
        hit_nxt   = lat_hit;
        index_nxt = lat_index;
        tag_nxt   = lat_tag;
        msg_nxt   = MSG_NONE;
        addr_nxt  = '0;

        case (fsm)
            IDLE: begin
                if (accept) begin
                    write_nxt = req_write;
                    hit_nxt   = req_hit;
                    index_nxt = req_index;
                    tag_nxt   = req_tag;
                    if (req_hit)
                        fsm_nxt = (req_write && cur_state == ST_S) ? MISS : DONE;
                    else if (cur_state == ST_M)
                        fsm_nxt = WB;
                    else
                        fsm_nxt = MISS;
                end
            end
            WB:      if (grant) fsm_nxt = MISS;
            MISS:    if (grant) fsm_nxt = DONE;
            DONE:    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase

        // Message fields are derived from the next state so they are registered and held until grant
        case (fsm_nxt)
            WB: begin
                msg_nxt  = MSG_WB;
                addr_nxt = {line_tag[index_nxt], index_nxt};
            end
            MISS: begin
                if (hit_nxt)
                    msg_nxt = MSG_INV;
                else if (write_nxt)
                    msg_nxt = MSG_WMISS;
                else
                    msg_nxt = MSG_RMISS;
                addr_nxt = {tag_nxt, index_nxt};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm       <= IDLE;
            lat_write <= 1'b0;
            lat_hit   <= 1'b0;
            lat_index <= '0;
            lat_tag   <= '0;
            req_ready <= 1'b1;
            bus_valid <= 1'b0;
            bus_msg   <= MSG_NONE;
            bus_addr  <= '0;
            done      <= 1'b0;
            result    <= 2'b00;
            for (int i = 0; i < LINES; i++) begin
                line_state[i] <= ST_I;
                line_tag[i]   <= '0;
            end
        end else begin
            fsm       <= fsm_nxt;
            lat_write <= write_nxt;
            lat_hit   <= hit_nxt;
            lat_index <= index_nxt;
            lat_tag   <= tag_nxt;
            req_ready <= (fsm_nxt == IDLE);
            bus_valid <= (fsm_nxt == WB) || (fsm_nxt == MISS);
            bus_msg   <= msg_nxt;
            bus_addr  <= addr_nxt;
            done      <= (fsm_nxt == DONE);
            result    <= (fsm_nxt == DONE) ? {write_nxt, hit_nxt} : 2'b00;

            // E -> M on a write hit needs no bus traffic
            if (accept && req_hit && req_write && cur_state == ST_E)
                line_state[req_index] <= ST_M;

            if (fsm == MISS && grant) begin
                line_state[lat_index] <= fill_state;
                line_tag[lat_index]   <= lat_tag;
            end
        end
    end

endmodule

// File: tb/tb_snoop_emissor_multi.sv
// Bench for snoop_emissor_multi: an MSI instance and a MESI instance, one active at a time,
// checked every cycle against a transaction-level coherence model plus literal expectations.
module tb_snoop_emissor_multi;

    localparam logic [2:0] M_WMISS = 3'b001;
    localparam logic [2:0] M_RMISS = 3'b010;
    localparam logic [2:0] M_INV   = 3'b011;
    localparam logic [2:0] M_WB    = 3'b100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sel   = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [1:0] req_index = 2'd0;
    logic [7:0] req_tag   = 8'h00;
    logic       bus_grant = 1'b0;
    logic       shared_in = 1'b0;

    logic       ready0, bv0, done0, ready1, bv1, done1;
    logic [2:0] msg0, msg1;
    logic [9:0] addr0, addr1;
    logic [1:0] res0, res1;

    logic       cur_ready, cur_bv, cur_done;
    logic [2:0] cur_msg;
    logic [9:0] cur_addr;
    logic [1:0] cur_result;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clock = ~clock;

    snoop_emissor_multi #(.LINES(4), .TAG_W(8), .EXCLUSIVE(0)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && !sel), .req_write(req_write), .req_index(req_index), .req_tag(req_tag),
        .req_ready(ready0), .bus_valid(bv0), .bus_msg(msg0), .bus_addr(addr0),
        .bus_grant(bus_grant && !sel), .shared_in(shared_in), .done(done0), .result(res0)
    );

    snoop_emissor_multi #(.LINES(4), .TAG_W(8), .EXCLUSIVE(1)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && sel), .req_write(req_write), .req_index(req_index), .req_tag(req_tag),
        .req_ready(ready1), .bus_valid(bv1), .bus_msg(msg1), .bus_addr(addr1),
        .bus_grant(bus_grant && sel), .shared_in(shared_in), .done(done1), .result(res1)
    );

    assign cur_ready  = sel ? ready1 : ready0;
    assign cur_bv     = sel ? bv1    : bv0;
    assign cur_done   = sel ? done1  : done0;
    assign cur_msg    = sel ? msg1   : msg0;
    assign cur_addr   = sel ? addr1  : addr0;
    assign cur_result = sel ? res1   : res0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, expv);
        end
    endtask

    // Coherence model: line states 0=I 1=S 2=M 3=E; expected bus messages as {msg, tag, idx}
    logic [1:0]  m_state [4];
    logic [7:0]  m_tag   [4];
    logic [12:0] exp_q   [$];
    logic [12:0] obs_log [$];
    logic        pending    = 1'b0;
    logic        exp_done   = 1'b0;
    logic        post_reset = 1'b0;
    logic [1:0]  exp_result = 2'b00;
    logic        pend_w;
    logic [1:0]  pend_idx;
    logic [7:0]  pend_tag;

    always @(negedge clock) begin
        logic do_done;
        logic hit;
        if (post_reset) begin
            chk("reset_ready", cur_ready, 1);
            chk("reset_bus_msg", cur_msg, 0);
            chk("reset_bus_addr", cur_addr, 0);
            chk("reset_result", cur_result, 0);
            post_reset = 1'b0;
        end
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_state[i] = 2'd0;
                m_tag[i]   = 8'h00;
            end
            exp_q.delete();
            pending    = 1'b0;
            exp_done   = 1'b0;
            post_reset = 1'b1;
        end else begin
            do_done  = exp_done;
            exp_done = 1'b0;
            chk("done", cur_done, do_done);
            if (do_done) begin
                chk("result", cur_result, exp_result);
                done_cnt++;
            end
            chk("req_ready", cur_ready, !pending);
            if (do_done) pending = 1'b0;
            chk("bus_valid", cur_bv, exp_q.size() != 0);
            if (cur_bv && exp_q.size() != 0) begin
                chk("bus_msg", cur_msg, exp_q[0][12:10]);
                chk("bus_addr", cur_addr, exp_q[0][9:0]);
                if (bus_grant) begin
                    obs_log.push_back({cur_msg, cur_addr});
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_tag[pend_idx]   = pend_tag;
                        m_state[pend_idx] = pend_w ? 2'd2 : ((sel && !shared_in) ? 2'd3 : 2'd1);
                        exp_done = 1'b1;
                    end
                end
            end
            if (req_valid && cur_ready) begin
                hit        = (m_state[req_index] != 2'd0) && (m_tag[req_index] == req_tag);
                pend_w     = req_write;
                pend_idx   = req_index;
                pend_tag   = req_tag;
                exp_result = {req_write, hit};
                pending    = 1'b1;
                if (hit) begin
                    if (req_write && m_state[req_index] == 2'd1)
                        exp_q.push_back({M_INV, req_tag, req_index});
                    else begin
                        if (req_write) m_state[req_index] = 2'd2;
                        exp_done = 1'b1;
                    end
                end else begin
                    if (m_state[req_index] == 2'd2)
                        exp_q.push_back({M_WB, m_tag[req_index], req_index});
                    exp_q.push_back({req_write ? M_WMISS : M_RMISS, req_tag, req_index});
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Issues one access, grants each bus message after gdel waiting cycles, returns at the done cycle
    task automatic do_req(input logic w, input logic [1:0] idx, input logic [7:0] tag, input logic sh,
                          input int gdel, output int cyc, output int res);
        int  lat;
        int  wcnt;
        int  budget;
        logic got;
        obs_log.delete();
        req_valid = 1'b1;
        req_write = w;
        req_index = idx;
        req_tag   = tag;
        shared_in = sh;
        budget = 0;
        while (!cur_ready && budget < 50) begin
            step();
            budget++;
        end
        if (!cur_ready) chk("accept_timeout", 0, 1);
        step();
        req_valid = 1'b0;
        lat  = 1;
        wcnt = 0;
        got  = 1'b0;
        res  = -1;
        while (!got && lat < 200) begin
            if (cur_done) begin
                got = 1'b1;
                res = cur_result;
            end else begin
                if (cur_bv) begin
                    if (wcnt >= gdel) begin
                        bus_grant = 1'b1;
                        wcnt = 0;
                    end else begin
                        bus_grant = 1'b0;
                        wcnt++;
                    end
                end else begin
                    bus_grant = 1'b0;
                end
                step();
                lat++;
            end
        end
        bus_grant = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        cyc = lat + 1;
    endtask

    function automatic int log_at(input int k);
        if (k < obs_log.size()) return obs_log[k];
        return -1;
    endfunction

    initial begin
        int cyc;
        int res;
        int d0;
        step();
        step();
        reset = 1'b0;

        // MSI: cold read miss, then read hit, then write hit on SHARED
        do_req(0, 2'd2, 8'h5A, 0, 0, cyc, res);
        chk("t1_cycles", cyc, 3);
        chk("t1_nmsg", obs_log.size(), 1);
        chk("t1_msg", log_at(0), {3'b010, 8'h5A, 2'd2});
        chk("t1_result", res, 0);
        do_req(0, 2'd2, 8'h5A, 0, 0, cyc, res);
        chk("t2_rd_cycles", cyc, 2);
        chk("t2_rd_nmsg", obs_log.size(), 0);
        chk("t2_rd_result", res, 1);
        do_req(1, 2'd2, 8'h5A, 0, 0, cyc, res);
        chk("t2_wr_msg", log_at(0), {3'b011, 8'h5A, 2'd2});
        chk("t2_wr_result", res, 3);

        // Dirty read miss with slow grants, then the SHARED result
        do_req(0, 2'd2, 8'h33, 0, 3, cyc, res);
        chk("t3_cycles", cyc, 10);
        chk("t3_wb", log_at(0), {3'b100, 8'h5A, 2'd2});
        chk("t3_rmiss", log_at(1), {3'b010, 8'h33, 2'd2});
        chk("t3_result", res, 0);
        do_req(0, 2'd2, 8'h33, 0, 0, cyc, res);
        chk("t3_hit_result", res, 1);
        do_req(1, 2'd2, 8'h33, 0, 0, cyc, res);
        chk("t3_inv", log_at(0), {3'b011, 8'h33, 2'd2});
        do_req(0, 2'd2, 8'h77, 0, 0, cyc, res);
        chk("t3_dirty_zero_wait_cycles", cyc, 4);
        chk("t3_dirty_wb", log_at(0), {3'b100, 8'h33, 2'd2});

        // MESI: exclusive fill, silent upgrade; then shared fill
        sel = 1'b1;
        do_reset();
        do_req(0, 2'd1, 8'h11, 0, 0, cyc, res);
        chk("t4_fill_msg", log_at(0), {3'b010, 8'h11, 2'd1});
        do_req(1, 2'd1, 8'h11, 0, 0, cyc, res);
        chk("t4_silent_cycles", cyc, 2);
        chk("t4_silent_nmsg", obs_log.size(), 0);
        chk("t4_silent_result", res, 3);
        do_req(0, 2'd1, 8'h22, 0, 0, cyc, res);
        chk("t4_modified_wb", log_at(0), {3'b100, 8'h11, 2'd1});
        do_reset();
        do_req(0, 2'd1, 8'h11, 1, 0, cyc, res);
        do_req(1, 2'd1, 8'h11, 1, 0, cyc, res);
        chk("t4_shared_inv", log_at(0), {3'b011, 8'h11, 2'd1});

        // Reset on the grant edge of a write miss
        sel = 1'b0;
        do_reset();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_index = 2'd1;
        req_tag   = 8'h44;
        step();
        req_valid = 1'b0;
        chk("t5_bus_valid", cur_bv, 1);
        bus_grant = 1'b1;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        bus_grant = 1'b0;
        chk("t5_ready", cur_ready, 1);
        chk("t5_done", cur_done, 0);
        step();
        chk("t5_done_later", cur_done, 0);
        do_req(0, 2'd1, 8'h44, 0, 0, cyc, res);
        chk("t5_line_invalid", log_at(0), {3'b010, 8'h44, 2'd1});
        chk("t5_result", res, 0);

        // Stray grant while idle, then back-to-back requests
        bus_grant = 1'b1;
        step();
        step();
        step();
        bus_grant = 1'b0;
        d0 = done_cnt;
        do_req(0, 2'd0, 8'hA0, 0, 0, cyc, res);
        chk("t6_first_result", res, 0);
        do_req(1, 2'd3, 8'hB3, 0, 1, cyc, res);
        chk("t6_second_msg", log_at(0), {3'b001, 8'hB3, 2'd3});
        chk("t6_second_result", res, 2);
        step();
        step();
        chk("t6_done_count", done_cnt - d0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/snoop_emissor_multi.md
# snoop_emissor_multi

Parametrised MSI/MESI snooping-coherence emitter that tracks coherence state and tag for `LINES` direct-mapped cache lines. It replaces the single-line emitter. It determines hit/miss internally, sequences the write-back and bus request for each processor access through a valid/grant handshake, and updates line state on completion. It sits between the processor-side cache controller and the shared snooping bus arbiter.

## Interface
- `LINES`, 4: number of tracked lines; power of two, ≥2; `IDX_W = $clog2(LINES)`
- `TAG_W`, 8: tag width
- `EXCLUSIVE`, 0: 1 enables the MESI E state; 0 gives pure MSI
- `clock` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in 1: processor access request
- `req_write` in 1: 1 = write, 0 = read
- `req_index` in IDX_W: line index
- `req_tag` in TAG_W: access tag
- `req_ready` out 1: request is accepted on an edge where `req_valid && req_ready`
- `bus_valid` out 1: bus message pending
- `bus_msg` out 3: 001 WRITE_MISS, 010 READ_MISS, 011 INVALIDATE, 100 WRITEBACK, 000 none
- `bus_addr` out TAG_W+IDX_W: {tag, index} of the message
- `bus_grant` in 1: arbiter accepts the pending message on this edge
- `shared_in` in 1: another cache holds the line; sampled on the READ_MISS grant edge
- `done` out 1: one-cycle completion pulse
- `result` out 2: valid with `done`: 00 READ_MISS, 01 READ_HIT, 10 WRITE_MISS, 11 WRITE_HIT

## Operation
- Per-line storage: `state[1:0]` (00 INVALIDO, 01 SHARED, 10 MODIFIED, 11 EXCLUSIVE) and `tag`.
- Hit condition: `state != INVALIDO && tag == req_tag`.
- Request fields are latched at acceptance.
- Controller FSM states: IDLE, WB, MISS, DONE. `req_ready = (fsm == IDLE)`.
- IDLE, access accepted:
  - hit → DONE
  - miss with resident line MODIFIED (tag mismatch) → WB
  - any other miss → MISS
- WB: `bus_valid = 1`, `bus_msg = 100`, `bus_addr = {old tag, index}`. On the grant edge → MISS.
- MISS: `bus_valid = 1`, `bus_msg = 010` (read) or `001` (write), `bus_addr = {req_tag, index}`. On the grant edge: write tag, set line state, → DONE.
- Write hit on SHARED: enters MISS with `bus_msg = 011`. On grant the line becomes MODIFIED.
- Per-line transitions:
  - INVALIDO, or any clean line with tag mismatch:
    - read → SHARED, or EXCLUSIVE if `EXCLUSIVE=1` and `shared_in=0`
    - write → MODIFIED
  - SHARED: read hit keeps SHARED (no bus); write hit → INVALIDATE, then MODIFIED.
  - EXCLUSIVE: read hit keeps EXCLUSIVE; write hit → MODIFIED silently (no bus); a miss behaves as for a clean line.
  - MODIFIED: hits stay MODIFIED (no bus); a miss takes WB, then a read or write miss as above.
- With `EXCLUSIVE=0`, state 11 is never written and `shared_in` is ignored.
- DONE: `done = 1` and `result = {write, hit}`, both registered. Returns to IDLE next cycle.
- `bus_grant` is ignored unless `bus_valid = 1`.
- `bus_valid`, `bus_msg` and `bus_addr` stay stable until the grant edge.

## Timing
- All outputs are registered.
- Reset values: every line INVALIDO with tag 0; FSM in IDLE; `req_ready = 1`; `bus_valid = 0`, `bus_msg = 000`, `bus_addr = 0`, `done = 0`, `result = 00`.
- Hit: accepted at edge t; `done` is high in cycle t+1; `req_ready` returns at t+2.
- Clean miss: `bus_valid` rises in cycle t+1. With grant sampled at edge g, the state update happens at g, `done` is high in g+1, and `bus_valid` is low in g+1.
- Dirty miss: the WRITEBACK grant at edge g1 is followed by the miss message from cycle g1+1. There is no idle cycle between the two messages.
- Zero-wait grant (grant already high): a clean miss completes in 3 cycles, a dirty miss in 4.
- Reset asserted mid-transaction: takes priority at that edge and aborts the access. No line update occurs, even if the grant arrives on the same edge. `done` is not pulsed.
- Simultaneous `req_valid` in DONE: not accepted (`req_ready = 0`); the request must be held.

## Test plan
- Reset, then read idx 2 tag 0x5A with `shared_in=0`, `EXCLUSIVE=0` → one READ_MISS (010) with `bus_addr={0x5A,2}`; line 2 becomes SHARED; `done` with `result=00`.
- Same config, repeat the read, then write idx 2 tag 0x5A → the read completes in 2 cycles with `result=01` and no `bus_valid`; the write issues INVALIDATE (011) and the line becomes MODIFIED with `result=11`.
- MODIFIED idx 2 tag 0x5A, read tag 0x33 with grant delayed 3 cycles each → WRITEBACK `{0x5A,2}`, then READ_MISS `{0x33,2}`, held stable while waiting; final state SHARED; `result=00`.
- `EXCLUSIVE=1`: read miss idx 1 with `shared_in=0` → EXCLUSIVE; a following write hit issues no bus message and the line becomes MODIFIED. Repeating with `shared_in=1` → SHARED.
- Reset asserted on the grant edge of a write miss → line stays INVALIDO; `done` stays 0; `req_ready = 1` next cycle.
- Grant pulsed while idle, plus back-to-back requests to lines 0 and 3 → stray grant ignored; requests are serialised; each produces exactly one `done`.
